// File: rtl/dmem_resp.sv
// Unified instruction/data memory responder with post-reset clear sequencer.
// Optional access counters are enabled with `define ACCESS_STATS_EN.
module dmem_resp #(
  parameter int unsigned MEM_WORDS = 4096,
  parameter logic [31:0] MEM_BASE  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [XLEN-1:0] icache_adr_i,
  output logic [31:0]     icache_instr_o,
  input  logic            adr_v_i,
  input  logic [XLEN-1:0] adr_i,
  input  logic            is_store_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [2:0]      access_size_i,
  output logic [XLEN-1:0] load_data_o,
  output logic            ready_o,
  output logic            err_o
`ifdef ACCESS_STATS_EN
  ,
  output logic [31:0]     stat_load_o,
  output logic [31:0]     stat_store_o,
  output logic [31:0]     stat_err_o
`endif
);

  localparam int unsigned     AW   = $clog2(MEM_WORDS);
  localparam logic [XLEN-1:0] BASE = XLEN'(MEM_BASE);

  typedef enum logic {CLEAR, READY} state_t;

  state_t          state;
  logic [AW-1:0]   clr_cnt;
  logic [31:0]     mem [MEM_WORDS];

  logic [XLEN-1:0] i_off, d_off;
  logic            i_in, d_in;
  logic [AW-1:0]   i_idx, d_idx;
  logic            size_ok, align_ok, err;
  logic [31:0]     rd_shift, rd_mask;

  logic            we;
  logic [AW-1:0]   waddr;
  logic [31:0]     wdata;
  logic [3:0]      wbe;

  // Range test: at or above base, and offset below 4*MEM_WORDS (power of 2).
  assign i_off = icache_adr_i - BASE;
  assign d_off = adr_i - BASE;
  assign i_in  = (icache_adr_i >= BASE) && ((i_off >> (AW + 2)) == '0);
  assign d_in  = (adr_i >= BASE) && ((d_off >> (AW + 2)) == '0);
  assign i_idx = i_off[AW+1:2];
  assign d_idx = d_off[AW+1:2];

  assign icache_instr_o = (state == READY && i_in && icache_adr_i[1:0] == 2'b00)
                          ? mem[i_idx] : NOP_INSTR;

  always_comb begin
    size_ok  = (access_size_i == 3'b001) || (access_size_i == 3'b010) ||
               (access_size_i == 3'b100);
    align_ok = 1'b1;
    if (access_size_i == 3'b010)
      align_ok = !adr_i[0];
    else if (access_size_i == 3'b100)
      align_ok = (adr_i[1:0] == 2'b00);
    err = (state == READY) && adr_v_i && !(d_in && size_ok && align_ok);
  end

  assign err_o = err;

  always_comb begin
    rd_shift = mem[d_idx] >> {adr_i[1:0], 3'b000};
    case (access_size_i)
      3'b001:  rd_mask = 32'h0000_00FF;
      3'b010:  rd_mask = 32'h0000_FFFF;
      default: rd_mask = 32'hFFFF_FFFF;
    endcase
    load_data_o = '0;
    if (state == READY && adr_v_i && !is_store_i && !err)
      load_data_o = XLEN'(rd_shift & rd_mask);
  end

  // Single write port: the clear sequencer owns it in CLEAR, stores in READY.
  always_comb begin
    we    = 1'b0;
    waddr = d_idx;
    wdata = store_data_i[31:0];
    wbe   = 4'hF;
    if (state == CLEAR) begin
      we    = 1'b1;
      waddr = clr_cnt;
      wdata = '0;
    end else begin
      we = adr_v_i && is_store_i && !err;
      case (access_size_i)
        3'b001: begin
          wbe   = 4'b0001 << adr_i[1:0];
          wdata = {4{store_data_i[7:0]}};
        end
        3'b010: begin
          wbe   = 4'b0011 << adr_i[1:0];
          wdata = {2{store_data_i[15:0]}};
        end
        default: begin
          wbe   = 4'hF;
          wdata = store_data_i[31:0];
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (we && reset_n) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wbe[b])
          mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_o <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          if (clr_cnt == AW'(MEM_WORDS - 1)) begin
            state   <= READY;
            ready_o <= 1'b1;
          end
        end
        READY: ;
        default: begin
          state   <= CLEAR;
          clr_cnt <= '0;
          ready_o <= 1'b0;
        end
      endcase
    end
  end

`ifdef ACCESS_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_load_o  <= '0;
      stat_store_o <= '0;
      stat_err_o   <= '0;
    end else if (state == READY) begin
      if (adr_v_i && !is_store_i && stat_load_o != '1)
        stat_load_o <= stat_load_o + 1'b1;
      if (we && stat_store_o != '1)
        stat_store_o <= stat_store_o + 1'b1;
      if (err && stat_err_o != '1)
        stat_err_o <= stat_err_o + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// Directed self-checking bench for dmem_resp with a 16-word array.
module tb_dmem_resp;

  localparam int unsigned MW = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] icache_adr_i;
  logic [31:0] icache_instr_o;
  logic        adr_v_i;
  logic [31:0] adr_i;
  logic        is_store_i;
  logic [31:0] store_data_i;
  logic [2:0]  access_size_i;
  logic [31:0] load_data_o;
  logic        ready_o;
  logic        err_o;
`ifdef ACCESS_STATS_EN
  logic [31:0] stat_load_o, stat_store_o, stat_err_o;
`endif

  int total = 0;
  int bad   = 0;

  dmem_resp #(
    .MEM_WORDS (MW),
    .MEM_BASE  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013),
    .XLEN      (32)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .icache_adr_i   (icache_adr_i),
    .icache_instr_o (icache_instr_o),
    .adr_v_i        (adr_v_i),
    .adr_i          (adr_i),
    .is_store_i     (is_store_i),
    .store_data_i   (store_data_i),
    .access_size_i  (access_size_i),
    .load_data_o    (load_data_o),
    .ready_o        (ready_o),
    .err_o          (err_o)
`ifdef ACCESS_STATS_EN
    ,
    .stat_load_o    (stat_load_o),
    .stat_store_o   (stat_store_o),
    .stat_err_o     (stat_err_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input logic exp_err);
    @(negedge clk);
    adr_v_i = 1'b1; is_store_i = 1'b1; adr_i = a; store_data_i = d; access_size_i = sz;
    #1;
    check("store_err", {31'b0, err_o}, {31'b0, exp_err});
    @(posedge clk);
    #1;
    adr_v_i = 1'b0; is_store_i = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [31:0] a, input logic [2:0] sz,
                         input logic [31:0] exp, input logic exp_err);
    @(negedge clk);
    adr_v_i = 1'b1; is_store_i = 1'b0; adr_i = a; access_size_i = sz;
    #1;
    check({tag, "_err"}, {31'b0, err_o}, {31'b0, exp_err});
    check(tag, load_data_o, exp);
    adr_v_i = 1'b0;
  endtask

  task automatic do_fetch(input string tag, input logic [31:0] a, input logic [31:0] exp);
    @(negedge clk);
    icache_adr_i = a;
    #1;
    check(tag, icache_instr_o, exp);
  endtask

  task automatic count_clear(input string tag);
    for (int k = 1; k <= int'(MW); k++) begin
      @(posedge clk);
      #1;
      check(tag, {31'b0, ready_o}, (k == int'(MW)) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    reset_n = 1'b0; icache_adr_i = '0; adr_v_i = 1'b0; adr_i = '0;
    is_store_i = 1'b0; store_data_i = '0; access_size_i = 3'b100;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'b0, ready_o}, 32'd0);
    check("rst_fetch", icache_instr_o, 32'h0000_0013);

    // Release reset with a load held active: it must be ignored during CLEAR.
    reset_n = 1'b1;
    adr_v_i = 1'b1; adr_i = 32'h10; access_size_i = 3'b100;
    for (int k = 1; k <= int'(MW); k++) begin
      @(posedge clk);
      #1;
      check("clr_ready", {31'b0, ready_o}, (k == int'(MW)) ? 32'd1 : 32'd0);
      if (k == 3) begin
        check("clr_fetch", icache_instr_o, 32'h0000_0013);
        check("clr_load", load_data_o, 32'h0);
        check("clr_err", {31'b0, err_o}, 32'd0);
      end
    end
    adr_v_i = 1'b0;

    do_load("top_word", 32'h3C, 3'b100, 32'h0, 1'b0);

    do_store(32'h10, 32'hDEADBEEF, 3'b100, 1'b0);
    do_store(32'h11, 32'h000000AA, 3'b001, 1'b0);
    do_load("w10", 32'h10, 3'b100, 32'hDEADAAEF, 1'b0);
    do_load("b13", 32'h13, 3'b001, 32'h000000DE, 1'b0);
    do_load("b12", 32'h12, 3'b001, 32'h000000AD, 1'b0);

    do_store(32'h22, 32'h00001234, 3'b010, 1'b0);
    do_load("w20", 32'h20, 3'b100, 32'h12340000, 1'b0);
    do_load("h22", 32'h22, 3'b010, 32'h00001234, 1'b0);
    do_fetch("f20", 32'h20, 32'h12340000);

    do_load("h21", 32'h21, 3'b010, 32'h0, 1'b1);
    do_store(32'h06, 32'hFFFFFFFF, 3'b100, 1'b1);
    do_load("w04", 32'h04, 3'b100, 32'h0, 1'b0);
    do_load("w08", 32'h08, 3'b100, 32'h0, 1'b0);
    do_load("sz011", 32'h10, 3'b011, 32'h0, 1'b1);
    do_load("w10b", 32'h10, 3'b100, 32'hDEADAAEF, 1'b0);

    do_store(32'h40, 32'h55555555, 3'b100, 1'b1);
    do_load("w00", 32'h00, 3'b100, 32'h0, 1'b0);
    do_fetch("f40", 32'h40, 32'h0000_0013);
    do_fetch("f22", 32'h22, 32'h0000_0013);

    // Fetch and store to the same word: fetch sees the old value until the edge.
    @(negedge clk);
    icache_adr_i = 32'h30;
    adr_v_i = 1'b1; is_store_i = 1'b1; adr_i = 32'h30; store_data_i = 32'hCAFEF00D;
    access_size_i = 3'b100;
    #1;
    check("f30_pre", icache_instr_o, 32'h0);
    @(posedge clk);
    #1;
    adr_v_i = 1'b0; is_store_i = 1'b0;
    check("f30_post", icache_instr_o, 32'hCAFEF00D);

`ifdef ACCESS_STATS_EN
    check("st_store", stat_store_o, 32'd4);
    check("st_err", stat_err_o, 32'd2);
    check("st_load", stat_load_o, 32'd0);
`endif

    // Restart the clear, abort it at clr_cnt=7, then watch a full clear.
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    check("mid_ready", {31'b0, ready_o}, 32'd0);
    reset_n = 1'b0;
    #2;
`ifdef ACCESS_STATS_EN
    check("pulse_load", stat_load_o, 32'd0);
    check("pulse_store", stat_store_o, 32'd0);
    check("pulse_err", stat_err_o, 32'd0);
`endif
    reset_n = 1'b1;
    count_clear("rclr_ready");
    do_load("w10_clr", 32'h10, 3'b100, 32'h0, 1'b0);
    do_fetch("f30_clr", 32'h30, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_resp.md
Name: dmem_resp

Overview:
Unified memory responder sitting at the far end of the core's two memory interfaces. It answers instruction fetches on the icache port and loads/stores on the data port from one internal word array. Sub-word stores use byte enables; alignment and range errors are flagged. After reset, a clear sequencer zeroes the array before the block reports ready. It is the standard memory model behind the core in simulation and FPGA builds.

Parameters:
MEM_WORDS, 4096, number of 32-bit words in the array (power of 2)
MEM_BASE, 32'h0000_0000, byte address mapped to word 0
NOP_INSTR, 32'h0000_0013, instruction returned while not ready or out of range

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
icache_adr_i  in  XLEN  fetch byte address
icache_instr_o  out  32  fetched instruction, combinational
adr_v_i  in  1  data access valid
adr_i  in  XLEN  data byte address
is_store_i  in  1  1=store, 0=load (qualified by adr_v_i)
store_data_i  in  XLEN  store data, LSB-aligned
access_size_i  in  3  one-hot: 3'b001 byte, 3'b010 half, 3'b100 word
load_data_o  out  XLEN  load data, addressed byte moved to bit 0, upper bits zero, combinational
ready_o  out  1  array cleared and accepting accesses
err_o  out  1  current data access is misaligned, out of range or has a bad size, combinational

Behaviour:
- Reset: reset_n is asynchronous, active-low; clock is clk. Asserting reset forces the FSM to CLEAR, sets clr_cnt=0 and ready_o=0. The remaining outputs follow the combinational rules below.
- FSM CLEAR: each cycle, writes 0 to word clr_cnt, then increments clr_cnt. The transition to READY happens on the cycle that writes word MEM_WORDS-1, so READY is reached exactly MEM_WORDS cycles after reset release. In CLEAR: icache_instr_o=NOP_INSTR, load_data_o=0, err_o=0, and all data accesses are ignored. There is no back-pressure; the core is held in reset externally until ready_o=1.
- FSM READY: terminal state, left only by reset. Reset asserted mid-clear or mid-operation restarts CLEAR from word 0. An in-flight store does not commit.
- Word index: (adr - MEM_BASE) >> 2. An address is in range iff MEM_BASE <= adr < MEM_BASE + 4*MEM_WORDS.
- Fetch: icache_instr_o = mem[index(icache_adr_i)]. It returns NOP_INSTR if the address is out of range or icache_adr_i[1:0] != 0. Fetch never raises err_o.
- Data error: with adr_v_i=1 in READY, err_o=1 if any of the following holds: the address is out of range; size is half and adr_i[0]=1; size is word and adr_i[1:0]!=0; access_size_i is not one-hot. Otherwise err_o=0. An errored store writes nothing. An errored load returns 0.
- Load: load_data_o = mem[index] >> (8*adr_i[1:0]), masked to 8, 16 or 32 bits by size. Sign extension is done by the core. When adr_v_i=0 or is_store_i=1, load_data_o=0.
- Store: commits at the posedge of the cycle in which adr_v_i=1, is_store_i=1 and there is no error.
  - Byte enables: byte -> 1<<adr[1:0]; half -> 2'b11<<adr[1:0]; word -> 4'hF.
  - Data is replicated into lanes: store_data_i[7:0] into every byte lane, store_data_i[15:0] into both half lanes.
- Store-then-load to the same address on the next cycle returns the new data, because the write is visible after the edge. A load in the same cycle as its own store is impossible, since there is one access per cycle.
- Fetch and store to the same word in the same cycle: the fetch returns the pre-store value.
- Array: one write port, driven by the CLEAR writer or by the store path (mutually exclusive by state). Reads are asynchronous.

Optional Feature:
Macro ACCESS_STATS_EN.
- Defined: adds output ports stat_load_o, stat_store_o and stat_err_o, each 32 bits.
  - Each is a saturating counter (holds at 32'hFFFF_FFFF), reset to 0 by reset_n.
  - stat_load_o increments on each READY-state cycle with adr_v_i=1 and is_store_i=0.
  - stat_store_o increments on each committed store.
  - stat_err_o increments on each cycle with err_o=1.
  - Counters do not count during CLEAR.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release with MEM_WORDS=16 -> ready_o=0 for exactly 16 cycles, then 1. A load to MEM_BASE+0x3C returns 0. Fetches during CLEAR return 32'h0000_0013.
- Word store 32'hDEADBEEF at 0x10, then byte store 32'h000000AA at 0x11 -> word load at 0x10 returns 32'hDEADAAEF; byte load at 0x13 returns 32'h000000DE.
- Half store 32'h1234 at 0x22 -> word load at 0x20 returns 32'h12340000; fetch at 0x20 returns 32'h12340000.
- Misaligned half load at 0x21, word store at 0x06, and size 3'b011 -> err_o=1 each cycle. Memory is unchanged and load_data_o=0.
- Out-of-range store at MEM_BASE + 4*MEM_WORDS -> err_o=1 and no wrap-around write to word 0. A fetch at the same address returns NOP_INSTR.
- reset_n pulsed low while clr_cnt=7 -> CLEAR restarts, ready_o rises a full MEM_WORDS cycles later. With ACCESS_STATS_EN, all counters read 0 after the pulse.
